// File: rtl/fifo_drain_pkg.sv
// Shared types and widths for the FIFO burst-drain consumer.
package fifo_drain_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    // One output-buffer entry: data word plus end-of-burst marker.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } ob_entry_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order valid/ready buffer holding {last, data} words popped
// from the FIFO; decouples the FIFO pop decision from downstream m_ready.
module drain_skid_buf
    import fifo_drain_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  ob_entry_t  push_entry,
    input  logic       pop,
    output logic [1:0] ob_cnt,
    output ob_entry_t  head
);

    logic [1:0] cnt_q, cnt_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    ob_entry_t  mem_q [0:1];
    ob_entry_t  mem_d [0:1];
    logic       push_ok;
    logic       pop_ok;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt order.
    assign push_ok = push && (cnt_q != 2'd2);
    assign pop_ok  = pop && (cnt_q != 2'd0);

    always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign ob_cnt = cnt_q;
    assign head   = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_burst_drain.sv
// Read-side FIFO consumer: groups popped words into full bursts or
// timeout/flush-triggered short bursts on a valid/ready output stream.
module fifo_burst_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int unsigned    TMR_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    drain_state_e     state_q, state_d;
    logic [CNT_W-1:0] beats_left_q, beats_left_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [1:0]       ob_cnt;
    ob_entry_t        ob_head;
    ob_entry_t        ob_push_entry;
    logic             ob_pop;

    // Pop only with room in the output buffer; never looks at m_ready.
    assign fifo_ren = (state_q != IDLE) && (beats_left_q != '0) &&
                      !fifo_empty && (ob_cnt != 2'd2);

    assign ob_push_entry = '{last: (beats_left_q == CNT_W'(1)), data: fifo_rdata};
    assign ob_pop        = (ob_cnt != 2'd0) && m_ready;

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        timer_d      = timer_q;

        // Idle-with-data timer, saturating so the flush condition persists.
        if (fifo_empty || (state_q != IDLE)) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + TMR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (fifo_count >= BURST_CNT) begin
                    state_d      = BURST;
                    beats_left_d = BURST_CNT;
                end else if ((flush || (timer_q == TMR_MAX)) && !fifo_empty) begin
                    state_d      = FLUSH;
                    beats_left_d = fifo_count;
                end
            end
            BURST, FLUSH: begin
                if (beats_left_q == '0) begin
                    state_d = IDLE;
                end else if (fifo_ren) begin
                    beats_left_d = beats_left_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            timer_q      <= timer_d;
        end
    end

    drain_skid_buf u_ob (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_ren),
        .push_entry (ob_push_entry),
        .pop        (ob_pop),
        .ob_cnt     (ob_cnt),
        .head       (ob_head)
    );

    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob_head.data;
    assign m_last  = ob_head.last;
    assign busy    = (state_q != IDLE) || (ob_cnt != 2'd0);

    // The upstream FIFO can never report more words than it holds.
    assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: bench-owned FIFO, burst-level
// reference model feeding an expected-word queue, independent output monitor.
module tb_fifo_burst_drain;
    import fifo_drain_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned TIMEOUT   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_rdata = '0;
    logic              fifo_empty = 1'b1;
    logic [CNT_W-1:0]  fifo_count = '0;
    logic              flush = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic [7:0] fifo_q[$];   // the FIFO as the DUT sees it, popped by fifo_ren
    logic [7:0] ref_fifo[$]; // reference view of queued words, popped by the model
    exp_t       sb_q[$];     // words the model says were emitted and not yet taken

    bit ref_in_burst;
    int ref_remaining;
    int ref_idle_cycles;
    bit ren_pending;
    int n_acc;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_count = CNT_W'(fifo_q.size());
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic model_clear();
        fifo_q.delete();
        ref_fifo.delete();
        sb_q.delete();
        ref_in_burst    = 1'b0;
        ref_remaining   = 0;
        ref_idle_cycles = 0;
        ren_pending     = 1'b0;
    endtask

    // One clock cycle: apply last edge's pop, optional write, inputs; then
    // predict this cycle's behaviour from the burst rules.
    task automatic cycle(input bit wr, input logic [7:0] wd, input bit fl, input bit rdy);
        int sz;
        bit exp_ren;
        exp_t e;
        @(negedge clk);
        if (ren_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (wr && fifo_q.size() < DEPTH) begin
            fifo_q.push_back(wd);
            ref_fifo.push_back(wd);
        end
        drive_fifo();
        flush   = fl;
        m_ready = rdy;
        #1;
        sz      = ref_fifo.size();
        exp_ren = ref_in_burst && ref_remaining > 0 && sz > 0 && sb_q.size() < 2;
        chk("fifo_ren", int'(fifo_ren), int'(exp_ren));
        chk("ren_while_empty", int'(fifo_ren && fifo_empty), 0);
        chk("m_valid", int'(m_valid), int'(sb_q.size() != 0));
        chk("busy", int'(busy), int'(ref_in_burst || sb_q.size() != 0));
        ren_pending = fifo_ren;
        if (!ref_in_burst) begin
            if (sz >= BURST_LEN) begin
                ref_in_burst  = 1'b1;
                ref_remaining = BURST_LEN;
            end else if ((fl || ref_idle_cycles == TIMEOUT - 1) && sz > 0) begin
                ref_in_burst  = 1'b1;
                ref_remaining = sz;
            end
            if (sz == 0) ref_idle_cycles = 0;
            else if (ref_idle_cycles < TIMEOUT - 1) ref_idle_cycles++;
        end else begin
            ref_idle_cycles = 0;
            if (exp_ren) begin
                e.data = ref_fifo.pop_front();
                e.last = (ref_remaining == 1);
                sb_q.push_back(e);
                ref_remaining--;
            end else if (ref_remaining == 0) begin
                ref_in_burst = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst m_valid", int'(m_valid), 0);
        chk("rst fifo_ren", int'(fifo_ren), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst m_last", int'(m_last), 0);
        chk("rst m_data", int'(m_data), 0);
        model_clear();
        drive_fifo();
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the expected queue.
    always @(negedge clk) begin
        #2;
        if (rst_n && m_valid) begin
            if (sb_q.size() == 0) begin
                chk("m_valid_unexpected", int'(m_valid), 0);
            end else begin
                chk("m_data", int'(m_data), int'(sb_q[0].data));
                chk("m_last", int'(m_last), int'(sb_q[0].last));
                if (m_ready) begin
                    void'(sb_q.pop_front());
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        n_acc = 0;
        model_clear();
        #1;
        pulse_reset();

        // Full burst of four known words.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA1 + i), 1'b0, 1'b1);
        idle(12, 1'b1);
        chk("t1 fifo empty", fifo_q.size(), 0);

        // Two words drained by timeout.
        for (int i = 0; i < 2; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        idle(40, 1'b1);

        // Back-pressure: six words with m_ready low, then release.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(10, 1'b0);
        chk("t3 fifo_count", int'(fifo_count), 4);
        idle(50, 1'b1);

        // Flush on an empty FIFO is forgotten; the later word waits for timeout.
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        idle(40, 1'b1);

        // Reset in the middle of a burst.
        base = n_acc;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        guard = 0;
        while (n_acc - base < 2 && guard < 50) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            guard++;
        end
        chk("t5 two words out", int'(n_acc - base >= 2), 1);
        @(negedge clk);
        pulse_reset();
        idle(20, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        idle(45, 1'b1);

        // Writes landing on the same cycles as the burst pops.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        idle(20, 1'b1);

        // Randomized traffic with flushes and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 2) == 0), 8'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end

        // Drain everything out.
        guard = 0;
        while ((busy || fifo_q.size() != 0 || sb_q.size() != 0) && guard < 500) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            guard++;
        end
        chk("final drain timeout", int'(guard < 500), 1);
        chk("final scoreboard empty", sb_q.size(), 0);
        chk("final fifo empty", fifo_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
Read-side consumer for the 16-deep, 8-bit FIFO. It pops words from the FIFO's combinational read port and presents them on a valid/ready output stream. Words are grouped into bursts:
- a full burst of BURST_LEN words once enough data is queued, or
- a short flush burst after a timeout or an explicit flush request.

A 2-entry output buffer provides full throughput with no combinational path from m_ready to fifo_ren.

Parameters:
DEPTH, 16, FIFO depth; fifo_count range 0..DEPTH
BURST_LEN, 4, words per full burst; legal 1..DEPTH
TIMEOUT, 32, idle cycles with non-empty FIFO before a flush burst; legal >=1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low; shared with the FIFO
fifo_ren  out  1  pop request to FIFO; the head word is consumed at this clk edge
fifo_rdata  in  8  FIFO head word, combinational, valid whenever !fifo_empty
fifo_empty  in  1  FIFO empty flag
fifo_count  in  5  FIFO occupancy 0..DEPTH
flush  in  1  single-cycle request to drain current contents as one burst
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  8  output word
m_last  out  1  marks the final word of a burst; qualified by m_valid
busy  out  1  high when state != IDLE or the output buffer is non-empty

Behaviour:
- Reset (async, rst_n low): state=IDLE, beats_left=0, timer=0, output buffer empty.
  - fifo_ren=0, m_valid=0, m_data=0, m_last=0, busy=0.
  - Reset mid-burst discards buffered words; no partial burst completes.
- States:
  - IDLE: no pops. Transition priority, evaluated each cycle:
    1. fifo_count >= BURST_LEN -> BURST, beats_left=BURST_LEN.
    2. (flush || timer==TIMEOUT-1) && !fifo_empty -> FLUSH, beats_left=fifo_count sampled that cycle.
    3. Otherwise stay in IDLE.
  - flush while the FIFO is empty is ignored and not remembered. flush outside IDLE is ignored.
  - Timer: 0 when fifo_empty or state != IDLE; otherwise increments and saturates at TIMEOUT-1.
  - BURST and FLUSH pop until beats_left reaches 0, then return to IDLE on the next edge.
  - A word is never popped in the same cycle as the IDLE exit decision, so the first pop occurs one cycle after the decision.
- Pop rule: fifo_ren = (state != IDLE) && beats_left != 0 && !fifo_empty && ob_cnt < 2.
  - fifo_ren must never be asserted while fifo_empty; the FIFO underflow skip path must never be triggered.
  - fifo_ren must not depend on m_ready.
- On a pop:
  - fifo_rdata is written into the output buffer tail.
  - The entry's last bit is set iff beats_left==1.
  - beats_left decrements.
- Output buffer:
  - 2 entries, FIFO-ordered; ob_cnt 0..2.
  - Push and pop in the same cycle leave ob_cnt unchanged.
  - m_valid = ob_cnt != 0. m_data and m_last come from the head entry.
  - Steady state with m_ready=1: ob_cnt=1, one word per cycle.
- Latency: the first word appears on m_valid 2 cycles after the IDLE->BURST/FLUSH decision edge (decision edge, pop edge, then visible).
- AXI-style stability: while m_valid && !m_ready, m_data and m_last hold stable and m_valid stays high.
- Concurrent FIFO writes during a burst are allowed.
  - beats_left is fixed at burst entry; extra words wait for the next burst.
  - BURST never starves, since count >= beats_left at entry.
  - FLUSH with concurrent writes still pops exactly the sampled count.
- Upstream writing while the FIFO is full (overwrite) is outside this block's contract; no compensation.
- Widths:
  - beats_left is 5 bits.
  - Timer width is $clog2(TIMEOUT)+1.
  - Comparisons are unsigned.

Decomposition:
- Package fifo_drain_pkg:
  - state enum {IDLE, BURST, FLUSH} as a 2-bit logic typedef.
  - Localparams DATA_W=8 and CNT_W=5.
- One natural sub-module: drain_skid_buf, the 2-entry valid/ready buffer carrying {last, data}, with push, pop, ob_cnt and head outputs.
- The FSM, timer and pop logic stay in the top module.

Test Plan:
- Write 4 words (0xA1..0xA4) while m_ready=1 -> exactly 4 fifo_ren pulses on consecutive cycles. m_data A1,A2,A3,A4 on consecutive cycles; m_last only with A4; FIFO ends empty; busy falls afterwards.
- Write 2 words, hold flush=0 -> 32 idle cycles, then FLUSH with beats_left=2. Both words are output; m_last is set on the 2nd.
- Write 6 words, hold m_ready=0 -> exactly 2 pops occur and fifo_count stays at 4. m_valid and m_data=word0 are stable. Releasing m_ready then delivers burst 1 (words 0..3, m_last on word3), followed by burst 2 of words 4..5 (via timeout or flush).
- Assert flush with an empty FIFO, then write 1 word -> no burst on the flush pulse. The word drains only after 32 cycles; fifo_ren is never high while fifo_empty.
- Pulse rst_n low mid-burst after 2 of 4 words are output -> m_valid, fifo_ren and busy drop immediately. After release, no output until new data meets a burst condition.
- During a burst, write 4 more words on the same cycles as the pops -> the current burst ends with m_last after exactly 4 words, and the next burst starts from IDLE.
